// File: rtl/diffusion_pkg.sv
// Shared definitions for the diffusion random-walk workers:
// FSM encoding, arithmetic defaults and the push-mass function.
package diffusion_pkg;

    localparam int DW_DEF        = 32;
    localparam int AW_DEF        = 16;
    localparam int FRAC_DEF      = 16;
    localparam int MAX_STEPS_DEF = 7;

    localparam logic [31:0] ALPHA_DEF = 32'h0000_2666;
    localparam logic [31:0] EPS_DEF   = 32'h0000_0010;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_EVAL   = 3'd3;
    localparam logic [2:0] S_PUSH   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Full-width product, shifted down, truncated to word width.
    function automatic logic [DW_DEF-1:0] mass_f(
        input logic [DW_DEF-1:0] r,
        input logic [DW_DEF-1:0] alpha
    );
        logic [2*DW_DEF-1:0] prod;
        prod = {{DW_DEF{1'b0}}, r} * {{DW_DEF{1'b0}}, alpha};
        return DW_DEF'(prod >> FRAC_DEF);
    endfunction

endpackage

// File: rtl/diffusion_push_mac.sv
// Registered push arithmetic: mass = (r*ALPHA)>>FRAC_BITS
// and the residual left behind, r - mass.
module diffusion_push_mac
    import diffusion_pkg::*;
#(
    parameter int                    DATA_WIDTH = DW_DEF,
    parameter int                    FRAC_BITS  = FRAC_DEF,
    parameter logic [DATA_WIDTH-1:0] ALPHA      = ALPHA_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] r_i,
    output logic [DATA_WIDTH-1:0] mass_o,
    output logic [DATA_WIDTH-1:0] rem_o
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   mass_d;
    logic [DATA_WIDTH-1:0]   mass_q;
    logic [DATA_WIDTH-1:0]   rem_q;

    assign prod   = {{DATA_WIDTH{1'b0}}, r_i}
                  * {{DATA_WIDTH{1'b0}}, ALPHA};
    assign mass_d = DATA_WIDTH'(prod >> FRAC_BITS);

    // Capture mass and remainder while the FSM evaluates a vertex.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mass_q <= '0;
            rem_q  <= '0;
        end else if (en_i) begin
            mass_q <= mass_d;
            rem_q  <= r_i - mass_d;
        end
    end

    assign mass_o = mass_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/diffusion_step_worker.sv
// One diffusion worker: sweeps its vertex slice once per lap,
// pushes scaled residual downstream, then syncs with its peer.
module diffusion_step_worker
    import diffusion_pkg::*;
#(
    parameter int                    DATA_WIDTH = DW_DEF,
    parameter int                    ADDR_WIDTH = AW_DEF,
    parameter int                    FRAC_BITS  = FRAC_DEF,
    parameter logic [DATA_WIDTH-1:0] ALPHA      = ALPHA_DEF,
    parameter logic [DATA_WIDTH-1:0] EPS        = EPS_DEF,
    parameter int                    MAX_STEPS  = MAX_STEPS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_nodes,
    input  logic                  rdy,
    input  logic [DATA_WIDTH-1:0] l_step,
    output logic                  finished,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  push_valid,
    input  logic                  push_ready,
    output logic [ADDR_WIDTH-1:0] push_addr,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic                  done
);

    localparam logic [DATA_WIDTH:0] LAST_STEP =
        (DATA_WIDTH+1)'(MAX_STEPS);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic                  fin_q, fin_d;

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] mass;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH:0]   step_next;
    logic                  lap_over;
    logic                  last_vtx;
    logic                  adv;

    assign addr      = base_q + idx_q;
    assign last_vtx  = (idx_q + ADDR_WIDTH'(1)) == num_q;
    assign step_next = {1'b0, l_step} + (DATA_WIDTH+1)'(1);
    assign lap_over  = step_next >= LAST_STEP;

    diffusion_push_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ALPHA      (ALPHA)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == S_EVAL),
        .r_i    (r_q),
        .mass_o (mass),
        .rem_o  (rem)
    );

    // Lap sequencing: per-vertex read/eval/push, then peer sync.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        idx_d   = idx_q;
        r_d     = r_q;
        fin_d   = fin_q;
        adv     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    num_d  = num_nodes;
                    idx_d  = '0;
                    if (num_nodes == '0) begin
                        state_d = S_FINISH;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                r_d     = rd_data;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (r_q < EPS) adv = 1'b1;
                else           state_d = S_PUSH;
            end
            S_PUSH: adv = push_ready;
            S_FINISH: begin
                // A zero-length slice re-raises after one low cycle
                // so the controller sees a fresh lap completion.
                if (!fin_q) begin
                    fin_d = 1'b1;
                end else if (rdy) begin
                    fin_d = 1'b0;
                    if (lap_over) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = '0;
                        state_d = (num_q == '0) ? S_FINISH : S_READ;
                    end
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            if (last_vtx) begin
                state_d = S_FINISH;
                fin_d   = 1'b1;
            end else begin
                idx_d   = idx_q + ADDR_WIDTH'(1);
                state_d = S_READ;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            r_q     <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            r_q     <= r_d;
            fin_q   <= fin_d;
        end
    end

    assign finished   = fin_q;
    assign rd_en      = (state_q == S_READ);
    assign rd_addr    = addr;
    assign push_valid = (state_q == S_PUSH);
    assign push_addr  = addr;
    assign push_data  = mass;
    assign wr_en      = (state_q == S_PUSH) && push_ready;
    assign wr_addr    = addr;
    assign wr_data    = rem;
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_diffusion_step_worker.sv
// Directed bench for diffusion_step_worker: memory model,
// sync-controller model and per-scenario checks.
module tb_diffusion_step_worker;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_nodes = '0;
    logic          rdy = 1'b0;
    logic [DW-1:0] l_step = '0;
    logic          finished;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          push_valid;
    logic          push_ready = 1'b0;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;
    logic          done;

    logic [DW-1:0] mem [0:255];

    logic          ls_load = 1'b0;
    logic [DW-1:0] ls_val = '0;
    logic          sync_auto = 1'b0;

    int total = 0;
    int bad = 0;

    int rd_cnt = 0;
    int wr_cnt = 0;
    int push_cnt = 0;
    int hs_err = 0;
    int sync_cnt = 0;
    logic [AW-1:0] rd_a [$];
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    logic [AW-1:0] push_a [$];
    logic [DW-1:0] push_d [$];

    always #5 clk = ~clk;

    diffusion_step_worker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_nodes  (num_nodes),
        .rdy        (rdy),
        .l_step     (l_step),
        .finished   (finished),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .done       (done)
    );

    // Memory with 1-cycle read latency, plus traffic logging.
    always @(posedge clk) begin
        rd_data <= rd_en ? mem[rd_addr[7:0]] : 32'hDEAD_BEEF;
        if (rd_en) begin
            rd_cnt <= rd_cnt + 1;
            rd_a.push_back(rd_addr);
        end
        if (wr_en) begin
            wr_cnt <= wr_cnt + 1;
            wr_a.push_back(wr_addr);
            wr_d.push_back(wr_data);
        end
        if (push_valid && push_ready) begin
            push_cnt <= push_cnt + 1;
            push_a.push_back(push_addr);
            push_d.push_back(push_data);
        end
        if (wr_en !== (push_valid && push_ready))
            hs_err <= hs_err + 1;
        if (finished && rdy)
            sync_cnt <= sync_cnt + 1;
    end

    // Sync controller model: bumps l_step on each accepted lap.
    always @(posedge clk) begin
        if (ls_load)
            l_step <= ls_val;
        else if (sync_auto && finished && rdy)
            l_step <= l_step + 1;
    end

    task automatic start_lap(input logic [AW-1:0] b,
                             input logic [AW-1:0] n);
        start = 1'b1;
        base_addr = b;
        num_nodes = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_lstep(input logic [DW-1:0] v);
        ls_val = v;
        ls_load = 1'b1;
        @(negedge clk);
        ls_load = 1'b0;
    endtask

    task automatic test_reset();
        logic [116:0] outs;
        int n;
        int w0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        outs = {finished, rd_en, wr_en, push_valid, done, rd_addr,
                wr_addr, wr_data, push_addr, push_data};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_init got=%h want=0", outs);
        end
        rst = 1'b1;
        mem[8'h20] = 32'h0001_0000;
        push_ready = 1'b0;
        start_lap(16'h0020, 16'd1);
        n = 0;
        while (!push_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (push_valid !== 1'b1 || push_addr !== 16'h0020 ||
            push_data !== 32'h2666) begin
            bad++;
            $display("FAIL reset_reach_push got=%b/%h/%h want=1/0020/2666",
                     push_valid, push_addr, push_data);
        end
        w0 = wr_cnt;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            outs = {finished, rd_en, wr_en, push_valid, done, rd_addr,
                    wr_addr, wr_data, push_addr, push_data};
            total++;
            if (outs !== '0) begin
                bad++;
                $display("FAIL reset_mid_push got=%h want=0", outs);
            end
        end
        rst = 1'b1;
        push_ready = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (wr_cnt !== w0) begin
            bad++;
            $display("FAIL reset_no_write got=%0d want=%0d", wr_cnt, w0);
        end
        total++;
        if ({finished, rd_en, push_valid, done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_idle got=%b want=0000",
                     {finished, rd_en, push_valid, done});
        end
    endtask

    task automatic test_single_lap();
        int n;
        int p0;
        int w0;
        int r0;
        int a0;
        mem[8'h10] = 32'h0001_0000;
        mem[8'h11] = 32'h0000_0008;
        mem[8'h12] = 32'h0002_0000;
        push_ready = 1'b1;
        rdy = 1'b0;
        p0 = push_a.size();
        w0 = wr_a.size();
        a0 = rd_a.size();
        r0 = rd_cnt;
        start_lap(16'h0010, 16'd3);
        n = 1;
        while (!finished && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 12 || finished !== 1'b1) begin
            bad++;
            $display("FAIL lap_latency got=%0d/%b want=12/1", n, finished);
        end
        total++;
        if (push_a.size() - p0 !== 2) begin
            bad++;
            $display("FAIL lap_push_count got=%0d want=2",
                     push_a.size() - p0);
        end
        total++;
        if (!(push_a.size() >= p0 + 2 && push_a[p0] === 16'h0010 &&
              push_d[p0] === 32'h2666 && push_a[p0+1] === 16'h0012 &&
              push_d[p0+1] === 32'h4CCC)) begin
            bad++;
            $display("FAIL lap_push_vals got=%0d entries want=10:2666,12:4ccc",
                     push_a.size() - p0);
        end
        total++;
        if (!(wr_a.size() == w0 + 2 && wr_a[w0] === 16'h0010 &&
              wr_d[w0] === 32'hD99A && wr_a[w0+1] === 16'h0012 &&
              wr_d[w0+1] === 32'h1B334)) begin
            bad++;
            $display("FAIL lap_writes got=%0d entries want=10:d99a,12:1b334",
                     wr_a.size() - w0);
        end
        total++;
        if (!(rd_cnt - r0 == 3 && rd_a.size() >= a0 + 3 &&
              rd_a[a0] === 16'h0010 && rd_a[a0+1] === 16'h0011 &&
              rd_a[a0+2] === 16'h0012)) begin
            bad++;
            $display("FAIL lap_reads got=%0d want=3 at 10,11,12",
                     rd_cnt - r0);
        end
        total++;
        if (hs_err !== 0) begin
            bad++;
            $display("FAIL lap_wr_in_handshake got=%0d want=0", hs_err);
        end
    endtask

    task automatic test_sync_hold();
        int r0;
        r0 = rd_cnt;
        repeat (10) begin
            @(negedge clk);
            total++;
            if (finished !== 1'b1 || rd_en !== 1'b0) begin
                bad++;
                $display("FAIL sync_hold got=%b/%b want=1/0",
                         finished, rd_en);
            end
        end
        total++;
        if (rd_cnt !== r0) begin
            bad++;
            $display("FAIL sync_no_read got=%0d want=%0d", rd_cnt, r0);
        end
        load_lstep(32'd2);
        push_ready = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        total++;
        if (finished !== 1'b0 || rd_en !== 1'b1 ||
            rd_addr !== 16'h0010) begin
            bad++;
            $display("FAIL sync_release got=%b/%b/%h want=0/1/0010",
                     finished, rd_en, rd_addr);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int w0;
        n = 0;
        while (!push_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (push_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_reach_push got=%b want=1", push_valid);
        end
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (push_valid !== 1'b1 || push_addr !== 16'h0010 ||
                push_data !== 32'h2666 || wr_en !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall%0d got=%b/%h/%h/%b want=1/0010/2666/0",
                         i, push_valid, push_addr, push_data, wr_en);
            end
            @(negedge clk);
        end
        total++;
        if (wr_cnt !== w0) begin
            bad++;
            $display("FAIL bp_no_early_write got=%0d want=%0d", wr_cnt, w0);
        end
        push_ready = 1'b1;
        #1;
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 16'h0010 ||
            wr_data !== 32'hD99A) begin
            bad++;
            $display("FAIL bp_accept got=%b/%h/%h want=1/0010/d99a",
                     wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        total++;
        if (push_valid !== 1'b0 || wr_cnt !== w0 + 1) begin
            bad++;
            $display("FAIL bp_after got=%b/%0d want=0/%0d",
                     push_valid, wr_cnt - w0, 1);
        end
        n = 0;
        while (!finished && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (finished !== 1'b1) begin
            bad++;
            $display("FAIL bp_lap_end got=%b want=1", finished);
        end
    endtask

    task automatic test_termination();
        int n;
        int s0;
        int r0;
        int p0;
        int w0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load_lstep(32'd0);
        mem[8'h40] = 32'h0001_0000;
        mem[8'h41] = 32'h0000_0004;
        push_ready = 1'b1;
        sync_auto = 1'b1;
        rdy = 1'b1;
        s0 = sync_cnt;
        r0 = rd_cnt;
        p0 = push_cnt;
        start_lap(16'h0040, 16'd2);
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL term_done got=%b want=1", done);
        end
        total++;
        if (sync_cnt - s0 !== 7 || l_step !== 32'd7) begin
            bad++;
            $display("FAIL term_laps got=%0d/%0d want=7/7",
                     sync_cnt - s0, l_step);
        end
        total++;
        if (rd_cnt - r0 !== 14 || push_cnt - p0 !== 7) begin
            bad++;
            $display("FAIL term_traffic got=%0d/%0d want=14/7",
                     rd_cnt - r0, push_cnt - p0);
        end
        r0 = rd_cnt;
        p0 = push_cnt;
        w0 = wr_cnt;
        start_lap(16'h0040, 16'd2);
        repeat (20) @(negedge clk);
        total++;
        if (rd_cnt !== r0 || push_cnt !== p0 || wr_cnt !== w0 ||
            done !== 1'b1 || finished !== 1'b0) begin
            bad++;
            $display("FAIL term_quiet got=%0d/%0d/%0d/%b/%b want=0/0/0/1/0",
                     rd_cnt - r0, push_cnt - p0, wr_cnt - w0,
                     done, finished);
        end
        sync_auto = 1'b0;
        rdy = 1'b0;
    endtask

    task automatic test_empty_slice();
        int n;
        int r0;
        int p0;
        int w0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load_lstep(32'd0);
        r0 = rd_cnt;
        p0 = push_cnt;
        w0 = wr_cnt;
        start_lap(16'h0050, 16'd0);
        n = 1;
        while (!finished && n < 4) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (finished !== 1'b1 || n > 2) begin
            bad++;
            $display("FAIL empty_finish got=%b@%0d want=1@<=2", finished, n);
        end
        repeat (3) @(negedge clk);
        total++;
        if (rd_cnt !== r0 || push_cnt !== p0 || wr_cnt !== w0) begin
            bad++;
            $display("FAIL empty_traffic got=%0d/%0d/%0d want=0/0/0",
                     rd_cnt - r0, push_cnt - p0, wr_cnt - w0);
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        total++;
        if (finished !== 1'b0) begin
            bad++;
            $display("FAIL empty_clear got=%b want=0", finished);
        end
        @(negedge clk);
        total++;
        if (finished !== 1'b1 || rd_cnt !== r0) begin
            bad++;
            $display("FAIL empty_reraise got=%b/%0d want=1/0",
                     finished, rd_cnt - r0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_single_lap();
        test_sync_hold();
        test_backpressure();
        test_termination();
        test_empty_slice();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/diffusion_step_worker.md
Name: diffusion_step_worker

Overview:
- One diffusion random-walk worker. Each lap it sweeps its vertex slice, pushes ALPHA-scaled residual mass downstream and writes back the reduced residual.
- Raises finished at end of lap, then waits for the dual-worker sync controller (rdy/l_step) to advance the lap.
- Sits directly upstream of the sync controller; one instance per worker (two in the dual configuration).

Parameters:
DATA_WIDTH, 32, residual/mass word width and l_step width
ADDR_WIDTH, 16, vertex address width
FRAC_BITS, 16, fractional bits of ALPHA
ALPHA, 32'h0000_2666, push fraction, unsigned fixed point Q(FRAC_BITS), ~0.15
EPS, 32'h0000_0010, residual threshold; vertices with r < EPS are skipped
MAX_STEPS, 7, number of laps before DONE

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins lap 0 from IDLE
base_addr  in  ADDR_WIDTH  first vertex of slice, sampled on start
num_nodes  in  ADDR_WIDTH  slice length, sampled on start
rdy  in  1  from sync controller
l_step  in  DATA_WIDTH  current lap from sync controller
finished  out  1  lap complete, to sync controller
rd_en  out  1  residual read request
rd_addr  out  ADDR_WIDTH  residual read address
rd_data  in  DATA_WIDTH  residual, valid exactly 1 cycle after rd_en
wr_en  out  1  residual write strobe
wr_addr  out  ADDR_WIDTH  residual write address
wr_data  out  DATA_WIDTH  new residual
push_valid  out  1  mass push valid
push_ready  in  1  downstream accept
push_addr  out  ADDR_WIDTH  source vertex of push
push_data  out  DATA_WIDTH  pushed mass
done  out  1  all MAX_STEPS laps complete, sticky until reset

Behaviour:
- Reset (rst==0 at edge): state IDLE; finished, rd_en, wr_en, push_valid, done = 0; all address/data outputs and idx = 0. Reset mid-lap abandons the lap; no further writes.
- States: IDLE, READ, WAIT, EVAL, PUSH, FINISH, DONE.
- IDLE: start==1 -> latch base/num; idx=0; go READ, or FINISH if num_nodes==0. start ignored in all other states.
- READ: rd_en=1 for one cycle, rd_addr = base+idx (mod 2^ADDR_WIDTH) -> WAIT.
- WAIT: capture rd_data into r -> EVAL.
- EVAL: mass = (r*ALPHA) >> FRAC_BITS; full 2*DATA_WIDTH product, truncated to DATA_WIDTH. If r < EPS: no push, no write -> advance. Else -> PUSH with push_data=mass, push_addr=base+idx, push_valid=1.
- PUSH: hold push_valid/addr/data stable until push_ready. In the handshake cycle (valid&ready), wr_en=1 for one cycle, wr_addr=push_addr, wr_data=r-mass. Drop push_valid next cycle -> advance.
- Advance: idx+1 == num -> FINISH, else idx++ and READ.
- Vertex cost: 3 cycles when skipped, 4 + stall cycles when pushed.
- FINISH: finished=1, held. At an edge with finished==1 and rdy==1 (both workers done; controller increments l_step on this same edge):
  - clear finished at that edge;
  - l_step+1 >= MAX_STEPS -> DONE, else idx=0 and READ (or FINISH again if num==0).
  - Because finished is cleared on that edge, l_step increments exactly once per lap.
- FINISH with rdy==0 (peer still working): hold finished=1, no activity.
- DONE: done=1, finished=0, no memory or push traffic until reset.
- l_step is compared only in FINISH; changes elsewhere are ignored.

Decomposition:
- Shared package diffusion_pkg: state encoding, ALPHA/FRAC_BITS/EPS defaults, and a mass function (multiply, shift, truncate) shared with the downstream accumulator.
- One natural sub-module: diffusion_push_mac (registered multiply/shift producing mass and r-mass). Everything else stays in the top FSM.

Test Plan:
- Reset: rst=0 for 3 cycles mid-PUSH -> all outputs 0, state IDLE, no wr_en after the reset edge.
- Single lap: base=0x10, num=3, r={0x10000,0x8,0x20000}, push_ready=1.
  - Pushes only 0x10 (mass 0x2666, wr 0xD99A) and 0x12 (mass 0x4CCC, wr 0x1B334).
  - 0x11 skipped; then finished=1.
- Backpressure: push_ready low 5 cycles -> push_valid/addr/data stable all 5; wr_en exactly once, in the accept cycle.
- Sync hold: finished=1, rdy=0 for 10 cycles -> finished held, no rd_en. Then rdy=1 with l_step=2 -> finished drops on that edge and a new lap starts at idx 0.
- Termination: MAX_STEPS=7, sync model increments l_step -> exactly 7 laps, done=1 after FINISH at l_step=6, no further traffic.
- Empty slice: num_nodes=0 -> finished=1 two cycles after start, zero rd_en/wr_en/push_valid.
